key_digit_capture: RTL and testbench

//  Downstream consumer of the 10-to-4 keypad priority encoder (F[3:0], valid).

---
 rtl/key_digit_if.sv | 26 ++
 rtl/key_digit_capture.sv | 124 ++++++++++++
 tb/tb_key_digit_capture.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/key_digit_if.sv
// Keypad-encoder to digit-capture bundle: encoder code/valid and clear in,
// accepted digit, strobe and entry buffer out.
interface key_digit_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [3:0]         F;
  logic               valid;
  logic               clear;
  logic [3:0]         digit;
  logic               digit_stb;
  logic [4*DEPTH-1:0] digits;
  logic [CW-1:0]      count;
  logic               ovf;

  modport master (
    output F, valid, clear,
    input  digit, digit_stb, digits, count, ovf
  );

  modport slave (
    input  F, valid, clear,
    output digit, digit_stb, digits, count, ovf
  );
endinterface

// File: rtl/key_digit_capture.sv
// Synchronises and debounces keypad encoder output, strobes once per genuine
// press, and shifts each accepted digit into a DEPTH-digit entry buffer.
module key_digit_capture #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DEPTH           = 4
) (
  input  logic        clk,
  input  logic        rst,
  key_digit_if.slave  kif
);
  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]    FULL    = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

  state_t             state_q, state_d;
  logic [3:0]         f_meta_q, f_s_q;
  logic               valid_meta_q, valid_s_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         cand_q, cand_d;
  logic [3:0]         digit_q, digit_d;
  logic               stb_q, stb_d;
  logic [4*DEPTH-1:0] digits_q, digits_d, digits_base;
  logic [4*DEPTH+3:0] digits_push;
  logic [CW-1:0]      count_q, count_d, count_base;
  logic               ovf_q, ovf_d;
  logic               key_ok;
  logic               accept;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == FULL) ? c : c + CW'(1);
  endfunction

  // Codes 10..15 are not keys, so they never start or sustain a press.
  assign key_ok = valid_s_q && (f_s_q <= 4'd9);

  always_ff @(posedge clk) begin
    if (rst) begin
      f_meta_q     <= '0;
      f_s_q        <= '0;
      valid_meta_q <= 1'b0;
      valid_s_q    <= 1'b0;
      state_q      <= IDLE;
      cnt_q        <= '0;
      cand_q       <= '0;
      digit_q      <= '0;
      stb_q        <= 1'b0;
      digits_q     <= '0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
    end else begin
      f_meta_q     <= kif.F;
      f_s_q        <= f_meta_q;
      valid_meta_q <= kif.valid;
      valid_s_q    <= valid_meta_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cand_q       <= cand_d;
      digit_q      <= digit_d;
      stb_q        <= stb_d;
      digits_q     <= digits_d;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    case (state_q)
      IDLE: begin
        if (key_ok) begin
          state_d = DEBOUNCE;
          cand_d  = f_s_q;
          cnt_d   = '0;
        end
      end
      DEBOUNCE: begin
        if (!key_ok || (f_s_q != cand_q)) state_d = IDLE;
        else if (cnt_q == CNT_MAX)        state_d = PRESSED;
        else                              cnt_d   = cnt_q + CNT_W'(1);
      end
      PRESSED: begin
        if (!valid_s_q) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end
      end
      RELEASE: begin
        if (valid_s_q)              state_d = PRESSED;
        else if (cnt_q == CNT_MAX)  state_d = IDLE;
        else                        cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // A clear coinciding with a push empties the buffer first, then the push lands.
  always_comb begin
    accept      = (state_q == DEBOUNCE) && key_ok && (f_s_q == cand_q) && (cnt_q == CNT_MAX);
    stb_d       = accept;
    digit_d     = accept ? cand_q : digit_q;
    digits_base = kif.clear ? '0 : digits_q;
    count_base  = kif.clear ? '0 : count_q;
    digits_push = {digits_base, cand_q};
    digits_d    = digits_base;
    count_d     = count_base;
    ovf_d       = kif.clear ? 1'b0 : ovf_q;
    if (accept) begin
      digits_d = digits_push[4*DEPTH-1:0];
      count_d  = sat_inc(count_base);
      if (count_base == FULL) ovf_d = 1'b1;
    end
  end

  assign kif.digit     = digit_q;
  assign kif.digit_stb = stb_q;
  assign kif.digits    = digits_q;
  assign kif.count     = count_q;
  assign kif.ovf       = ovf_q;
endmodule

// File: tb/tb_key_digit_capture.sv
// Bench for key_digit_capture: directed scenarios plus random key activity,
// compared every cycle against a run-length/queue model of the keypad rules.
module tb_key_digit_capture;
  localparam int DB    = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  key_digit_if #(.DEPTH(DEPTH)) kif ();

  key_digit_capture #(.DEBOUNCE_CYCLES(DB), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .kif (kif)
  );

  int checks = 0;
  int errors = 0;
  int stb_cnt = 0;
  bit cmp_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: inputs reach the decision logic two edges late; a press is accepted
  // after DB+1 consecutive identical legal samples, released after DB+1 quiet samples.
  logic [3:0]  s1f, s2f, cand;
  logic        s1v, s2v;
  bit          held;
  int          run, quiet;
  logic [3:0]  m_digit;
  logic        m_stb, m_ovf;
  logic [3:0]  q[$];
  logic [15:0] m_digits;
  int          m_count;

  always @(posedge clk) begin
    bit ok, acc;
    if (rst) begin
      s1f = 0; s1v = 0; s2f = 0; s2v = 0; cand = 0;
      held = 0; run = 0; quiet = 0;
      m_digit = 0; m_stb = 0; m_ovf = 0;
      q.delete();
    end else begin
      ok  = s2v && (s2f <= 9);
      acc = 0;
      if (!held) begin
        if (run == 0) begin
          if (ok) begin run = 1; cand = s2f; end
        end else if (ok && s2f == cand) begin
          run++;
          if (run == DB + 1) begin acc = 1; held = 1; quiet = 0; run = 0; end
        end else run = 0;
      end else begin
        if (s2v) quiet = 0;
        else begin
          quiet++;
          if (quiet == DB + 1) begin held = 0; run = 0; end
        end
      end
      m_stb = acc;
      if (acc) m_digit = cand;
      if (kif.clear) begin q.delete(); m_ovf = 0; end
      if (acc) begin
        q.push_front(cand);
        if (q.size() > DEPTH) begin void'(q.pop_back()); m_ovf = 1; end
      end
      s2f = s1f; s2v = s1v; s1f = kif.F; s1v = kif.valid;
    end
    m_digits = '0;
    foreach (q[i]) m_digits[4*i +: 4] = q[i];
    m_count = q.size();
  end

  always @(negedge clk) begin
    if (kif.digit_stb === 1'b1) stb_cnt++;
    if (cmp_en) begin
      chk("digit",     32'(kif.digit),     32'(m_digit));
      chk("digit_stb", 32'(kif.digit_stb), 32'(m_stb));
      chk("digits",    32'(kif.digits),    32'(m_digits));
      chk("count",     32'(kif.count),     32'(m_count));
      chk("ovf",       32'(kif.ovf),       32'(m_ovf));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic press(input logic [3:0] code, input int on, input int off);
    kif.F = code; kif.valid = 1'b1; tick(on);
    kif.valid = 1'b0; tick(off);
  endtask

  initial begin
    int n;
    logic [3:0] code;
    int on, off;
    kif.F = 0; kif.valid = 0; kif.clear = 0;
    rst = 1'b1;
    tick(3);
    chk("rst_digit",  32'(kif.digit), 0);
    chk("rst_stb",    32'(kif.digit_stb), 0);
    chk("rst_digits", 32'(kif.digits), 0);
    chk("rst_count",  32'(kif.count), 0);
    chk("rst_ovf",    32'(kif.ovf), 0);
    cmp_en = 1;
    rst = 1'b0;
    tick(2);

    // Single clean press of 7; strobe expected on the 7th edge counting the sampling edge.
    stb_cnt = 0;
    kif.F = 7; kif.valid = 1'b1; n = 0;
    while (n < 30) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (kif.digit_stb === 1'b1) break;
    end
    chk("t2_latency", 32'(n), 7);
    tick(13);
    kif.valid = 1'b0; tick(20);
    chk("t2_strobes", 32'(stb_cnt), 1);
    chk("t2_digit",   32'(kif.digit), 7);
    chk("t2_digits",  32'(kif.digits), 32'h0007);
    chk("t2_count",   32'(kif.count), 1);
    chk("t2_model",   32'(m_digits), 32'h0007);

    // Press bounce, long hold, release bounce.
    stb_cnt = 0;
    kif.F = 3;
    repeat (3) begin kif.valid = 1; tick(2); kif.valid = 0; tick(2); end
    kif.valid = 1; tick(20);
    repeat (3) begin kif.valid = 0; tick(2); kif.valid = 1; tick(2); end
    kif.valid = 0; tick(20);
    chk("t3_strobes", 32'(stb_cnt), 1);
    chk("t3_digit",   32'(kif.digit), 3);

    // Overflow the buffer, then clear it.
    kif.clear = 1; tick(1); kif.clear = 0;
    for (int d = 1; d <= 5; d++) press(4'(d), 12, 12);
    chk("t4_digits", 32'(kif.digits), 32'h2345);
    chk("t4_count",  32'(kif.count), 4);
    chk("t4_ovf",    32'(kif.ovf), 1);
    chk("t4_model",  32'(m_digits), 32'h2345);
    kif.clear = 1; tick(1); kif.clear = 0;
    chk("t4_clr_digits", 32'(kif.digits), 0);
    chk("t4_clr_count",  32'(kif.count), 0);
    chk("t4_clr_ovf",    32'(kif.ovf), 0);

    // Illegal code, then code change mid-debounce.
    press(4'd1, 12, 12);
    stb_cnt = 0;
    press(4'd12, 20, 12);
    chk("t5_illegal_strobes", 32'(stb_cnt), 0);
    kif.F = 4; kif.valid = 1; tick(3);
    kif.F = 6; tick(15);
    kif.valid = 0; tick(15);
    chk("t5_strobes", 32'(stb_cnt), 1);
    chk("t5_digit",   32'(kif.digit), 6);

    // Clear coinciding with the accepting edge of 9.
    kif.F = 9; kif.valid = 1; tick(6);
    kif.clear = 1; tick(1); kif.clear = 0;
    tick(10);
    kif.valid = 0; tick(15);
    chk("t6_digits", 32'(kif.digits), 32'h0009);
    chk("t6_count",  32'(kif.count), 1);
    chk("t6_ovf",    32'(kif.ovf), 0);

    // Reset mid-debounce aborts the press.
    stb_cnt = 0;
    kif.F = 5; kif.valid = 1; tick(4);
    rst = 1; tick(1);
    rst = 0; kif.valid = 0; tick(20);
    chk("t6_rst_strobes", 32'(stb_cnt), 0);
    chk("t6_rst_digit",   32'(kif.digit), 0);

    // Random key activity with occasional clear, glitch and reset.
    for (int seg = 0; seg < 250; seg++) begin
      code = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      on  = $urandom_range(1, 12);
      off = $urandom_range(1, 12);
      kif.F = code; kif.valid = 1;
      for (int i = 0; i < on; i++) begin
        if ($urandom_range(0, 14) == 0) kif.F = 4'($urandom_range(0, 15));
        kif.clear = ($urandom_range(0, 29) == 0);
        rst = ($urandom_range(0, 399) == 0);
        tick(1);
      end
      kif.valid = 0;
      for (int i = 0; i < off; i++) begin
        kif.clear = ($urandom_range(0, 29) == 0);
        rst = ($urandom_range(0, 399) == 0);
        tick(1);
      end
    end
    rst = 0; kif.clear = 0;
    tick(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
